int_to_ieee_seq: RTL and testbench

INT_TO_IEEE_SEQ -- requirements
Module: int_to_ieee_seq

---
 rtl/int_to_ieee_seq.sv | 168 ++++++++++++++++
 tb/tb_int_to_ieee_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_ieee_seq.sv
// int_to_ieee_seq: sequential fixed-point to IEEE-754 single converter.
// Normalises one bit per cycle, then rounds to nearest, ties to even.
module int_to_ieee_seq #(
   parameter int INT_W  = 16,
   parameter int FRAC_W = 8,
   parameter bit SIGNED = 1'b1,
   localparam int W     = INT_W + FRAC_W,
   localparam int FW1   = (FRAC_W > 0) ? FRAC_W : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [INT_W-1:0]  int_in,
   input  logic [FW1-1:0]    frac_in,
   output logic              busy,
   output logic              done,
   output logic [31:0]       out,
   output logic [22:0]       mantissa,
   output logic [7:0]        exponent,
   output logic              inexact
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      NORM,
      ROUND,
      DONE
   } state_t;

   localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
   localparam logic [7:0]   EBASE = 8'(126 + INT_W);

   state_t        state;
   state_t        nxt;

   logic [W-1:0]  opnd;
   logic [W-1:0]  op_q;
   logic [W-1:0]  mag_q;
   logic          sgn_q;
   logic [6:0]    s_q;
   logic [31:0]   res_q;
   logic          rinx_q;
   logic [31:0]   out_q;
   logic          inx_q;
   logic          done_q;
   logic          busy_c;

   logic          sgn_c;
   logic [W-1:0]  mag_c;
   logic [86:0]   ext;
   logic [22:0]   mant_t;
   logic          grd;
   logic          stk;
   logic          rup;
   logic [23:0]   rnd;
   logic          carry;
   logic [7:0]    exp_f;
   logic [22:0]   mant_f;
   logic [31:0]   res_c;
   logic          rinx_c;

   generate
      if (FRAC_W > 0) begin : g_frac
         assign opnd = {int_in, frac_in};
      end else begin : g_nofrac
         logic unused_frac;
         assign unused_frac = frac_in[0];
         assign opnd = int_in;
      end
   endgenerate

   // sign and magnitude of the captured operand
   always_comb begin
      sgn_c = (SIGNED != 1'b0) ? op_q[W-1] : 1'b0;
      mag_c = sgn_c ? (~op_q + ONE) : op_q;
   end

   // round the normalised magnitude into single-precision fields
   always_comb begin
      ext    = {mag_q[W-2:0], {(88-W){1'b0}}};
      mant_t = ext[86:64];
      grd    = ext[63];
      stk    = |ext[62:0];
      rup    = grd & (stk | mant_t[0]);
      rnd    = {1'b0, mant_t} + {23'b0, rup};
      carry  = rnd[23];
      mant_f = carry ? 23'b0 : rnd[22:0];
      exp_f  = EBASE - {1'b0, s_q} + {7'b0, carry};
      res_c  = {sgn_q, exp_f, mant_f};
      rinx_c = grd | stk;
      if (mag_q == '0) begin
         res_c  = 32'h0;
         rinx_c = 1'b0;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // next-state: NORM looks one bit ahead so it lasts exactly s cycles
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = LOAD;
         LOAD:    nxt = ((mag_c == '0) || mag_c[W-1]) ? ROUND : NORM;
         NORM:    if (mag_q[W-2]) nxt = ROUND;
         ROUND:   nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      busy_c = (state != IDLE);
   end

   // datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         mag_q  <= '0;
         sgn_q  <= 1'b0;
         s_q    <= 7'd0;
         res_q  <= 32'h0;
         rinx_q <= 1'b0;
         out_q  <= 32'h0;
         inx_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (start) op_q <= opnd;
            LOAD: begin
               sgn_q <= sgn_c;
               mag_q <= mag_c;
               s_q   <= 7'd0;
            end
            NORM: begin
               mag_q <= mag_q << 1;
               s_q   <= s_q + 7'd1;
            end
            ROUND: begin
               res_q  <= res_c;
               rinx_q <= rinx_c;
            end
            DONE: begin
               out_q  <= res_q;
               inx_q  <= rinx_q;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy     = busy_c;
   assign done     = done_q;
   assign out      = out_q;
   assign mantissa = out_q[22:0];
   assign exponent = out_q[30:23];
   assign inexact  = inx_q;

endmodule

// File: tb/tb_int_to_ieee_seq.sv
// tb_int_to_ieee_seq: scoreboard bench for int_to_ieee_seq.
// Two instances: default 16.8 signed, and 32.0 unsigned.
module tb_int_to_ieee_seq;

   typedef struct {
      logic [31:0] o;
      logic        x;
      int          lat;
      int          c0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;

   logic        start0;
   logic [15:0] int0;
   logic [7:0]  frac0;
   logic        busy0, done0, inexact0;
   logic [31:0] out0;
   logic [22:0] mantissa0;
   logic [7:0]  exponent0;

   logic        start1;
   logic [31:0] int1;
   logic        busy1, done1, inexact1;
   logic [31:0] out1;
   logic [22:0] mantissa1;
   logic [7:0]  exponent1;

   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        m0, m1;
   logic [31:0] last0 = 32'h0;

   int          total = 0;
   int          bad = 0;

   int_to_ieee_seq u0 (
      .clk      (clk),
      .rst      (rst),
      .start    (start0),
      .int_in   (int0),
      .frac_in  (frac0),
      .busy     (busy0),
      .done     (done0),
      .out      (out0),
      .mantissa (mantissa0),
      .exponent (exponent0),
      .inexact  (inexact0)
   );

   int_to_ieee_seq #(
      .INT_W  (32),
      .FRAC_W (0),
      .SIGNED (1'b0)
   ) u1 (
      .clk      (clk),
      .rst      (rst),
      .start    (start1),
      .int_in   (int1),
      .frac_in  (1'b0),
      .busy     (busy1),
      .done     (done1),
      .out      (out1),
      .mantissa (mantissa1),
      .exponent (exponent1),
      .inexact  (inexact1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // reference: leading-one search, shift and integer remainder rounding
   function automatic void model(input logic [63:0] raw, input int w,
                                 input int fw, input bit sg,
                                 output logic [31:0] o, output logic x,
                                 output int lat);
      logic [63:0] mask, mag, q, rem, half;
      logic        sn;
      int          p, sh, e;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      mag  = raw & mask;
      sn   = sg && mag[w-1];
      if (sn) mag = (~mag + 64'd1) & mask;
      o = 32'h0;
      x = 1'b0;
      lat = 4;
      if (mag == 64'd0) return;
      p = 0;
      for (int i = 0; i < 64; i++) if (mag[i]) p = i;
      lat = 4 + (w - 1 - p);
      e = 127 + p - fw;
      if (p <= 23) begin
         q = mag << (23 - p);
      end else begin
         sh   = p - 23;
         q    = mag >> sh;
         rem  = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         x    = (rem != 64'd0);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
         if (q[24]) begin
            q = q >> 1;
            e = e + 1;
         end
      end
      o = {sn, e[7:0], q[22:0]};
   endfunction

   task automatic issue(input int sel, input logic [31:0] iv,
                        input logic [7:0] fv, input logic [31:0] eo,
                        input logic ex, input int el);
      exp_t e;
      @(negedge clk);
      e.o   = eo;
      e.x   = ex;
      e.lat = el;
      e.c0  = cyc;
      if (sel == 0) begin
         int0   = iv[15:0];
         frac0  = fv;
         start0 = 1'b1;
         q0.push_back(e);
      end else begin
         int1   = iv;
         start1 = 1'b1;
         q1.push_back(e);
      end
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic issue_m(input int sel, input logic [31:0] iv,
                          input logic [7:0] fv);
      logic [31:0] o;
      logic        x;
      int          lat;
      if (sel == 0) model({40'd0, iv[15:0], fv}, 24, 8, 1'b1, o, x, lat);
      else          model({32'd0, iv}, 32, 0, 1'b0, o, x, lat);
      issue(sel, iv, fv, o, x, lat);
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         chk("timeout", 64'(q0.size() + q1.size()), 64'd0);
         q0.delete();
         q1.delete();
      end
      @(negedge clk);
   endtask

   // scoreboard: pop and compare on every done pulse
   always @(negedge clk) begin
      if (!rst && done0) begin
         if (q0.size() == 0) begin
            chk("d0_spurious", 64'd1, 64'd0);
         end else begin
            m0 = q0.pop_front();
            chk("d0_out", 64'(out0), 64'(m0.o));
            chk("d0_exp", 64'(exponent0), 64'(m0.o[30:23]));
            chk("d0_man", 64'(mantissa0), 64'(m0.o[22:0]));
            chk("d0_inx", 64'(inexact0), 64'(m0.x));
            chk("d0_lat", 64'(cyc - m0.c0), 64'(m0.lat));
            last0 = out0;
         end
      end
      if (!rst && done1) begin
         if (q1.size() == 0) begin
            chk("d1_spurious", 64'd1, 64'd0);
         end else begin
            m1 = q1.pop_front();
            chk("d1_out", 64'(out1), 64'(m1.o));
            chk("d1_inx", 64'(inexact1), 64'(m1.x));
            chk("d1_lat", 64'(cyc - m1.c0), 64'(m1.lat));
         end
      end
   end

   initial begin
      rst    = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      int0   = 16'h0;
      frac0  = 8'h0;
      int1   = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy0), 64'd0);
      chk("rst_done", 64'(done0), 64'd0);
      chk("rst_out", 64'(out0), 64'd0);
      chk("rst_inx", 64'(inexact0), 64'd0);
      chk("rst_busy1", 64'(busy1), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(0, 32'h4, 8'h00, 32'h40800000, 1'b0, 17);
      chk("busy_run", 64'(busy0), 64'd1);
      drain();
      issue(0, 32'h6, 8'h80, 32'h40D00000, 1'b0, 17);
      drain();
      issue(0, 32'hFFFF, 8'h00, 32'hBF800000, 1'b0, 19);
      drain();
      issue(0, 32'h8000, 8'h00, 32'hC7000000, 1'b0, 4);
      drain();
      issue(0, 32'h0, 8'h00, 32'h00000000, 1'b0, 4);
      drain();
      issue(1, 32'h01000001, 8'h00, 32'h4B800000, 1'b1, 11);
      drain();
      issue(1, 32'h01000003, 8'h00, 32'h4B800002, 1'b1, 11);
      drain();
      issue(1, 32'hFFFFFFFF, 8'h00, 32'h4F800000, 1'b1, 4);
      drain();

      for (int i = 0; i < 10; i++) begin
         issue_m(0, $urandom, 8'($urandom));
         issue_m(1, $urandom >> $urandom_range(0, 31), 8'h00);
         drain();
      end

      issue(0, 32'h4, 8'h00, 32'h40800000, 1'b0, 17);
      repeat (3) @(negedge clk);
      int0   = 16'h6;
      frac0  = 8'h80;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      drain();
      repeat (25) @(negedge clk);
      chk("hold_out", 64'(out0), 64'(last0));
      chk("hold_done", 64'(done0), 64'd0);

      issue(0, 32'h4, 8'h00, 32'h40800000, 1'b0, 17);
      repeat (4) @(negedge clk);
      chk("busy_norm", 64'(busy0), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      q0.delete();
      chk("mid_busy", 64'(busy0), 64'd0);
      chk("mid_done", 64'(done0), 64'd0);
      chk("mid_out", 64'(out0), 64'd0);
      chk("mid_exp", 64'(exponent0), 64'd0);
      chk("mid_man", 64'(mantissa0), 64'd0);
      chk("mid_inx", 64'(inexact0), 64'd0);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      issue(0, 32'h6, 8'h80, 32'h40D00000, 1'b0, 17);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
